// File: rtl/kyber_pke_enc.sv
// Kyber PKE message-encoding front end: loads a 2^(DEPTH-3)-byte message, then
// streams Decompress_q(Decode_1(m),1) coefficients (0 or 1665), one per cycle.
module kyber_pke_enc #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             readin,
    input  logic             full_in,
    input  logic [7:0]       kyber_din,
    input  logic [7:0]       kyber_in_index,
    output logic             readin_ok,
    output logic             done,
    output logic             coef_valid,
    output logic [DEPTH-1:0] coef_index,
    output logic [11:0]      coef_out
);

    localparam int AW = DEPTH - 3;
    localparam int NB = 1 << AW;
    localparam logic [DEPTH-1:0] ONE  = 1;
    localparam logic [DEPTH-1:0] LAST = '1;
    localparam logic [11:0] HALF_Q = 12'd1665;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [NB-1:0][7:0]   buf_q, buf_d;
    logic [DEPTH-1:0]     cnt_q, cnt_d;
    logic                 readin_ok_q, readin_ok_d;
    logic                 done_q, done_d;
    logic                 coef_valid_q, coef_valid_d;
    logic [DEPTH-1:0]     coef_index_q, coef_index_d;
    logic [11:0]          coef_out_q, coef_out_d;

    logic [AW-1:0]        wr_addr;
    logic                 msg_bit;
    logic                 unused_idx;

    // Upper index bits are ignored so out-of-range addresses wrap.
    assign wr_addr    = kyber_in_index[AW-1:0];
    assign unused_idx = ^kyber_in_index;
    assign msg_bit    = buf_q[cnt_q[DEPTH-1:3]][cnt_q[2:0]];

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        coef_valid_d = 1'b0;
        coef_index_d = '0;
        coef_out_d   = '0;
        case (state_q)
            S_IDLE: if (set) state_d = S_LOAD;
            S_LOAD: begin
                if (readin) buf_d[wr_addr] = kyber_din;
                if (full_in) begin
                    state_d = S_ENC;
                    cnt_d   = '0;
                end
            end
            S_ENC: begin
                coef_valid_d = 1'b1;
                coef_index_d = cnt_q;
                coef_out_d   = msg_bit ? HALF_Q : 12'd0;
                cnt_d        = cnt_q + ONE;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: if (!set) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        readin_ok_d = (state_d == S_LOAD);
        // done follows set while parked in DONE; it drops on the edge that leaves.
        done_d      = (state_q == S_DONE) && set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            readin_ok_q  <= 1'b0;
            done_q       <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_index_q <= '0;
            coef_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            readin_ok_q  <= readin_ok_d;
            done_q       <= done_d;
            coef_valid_q <= coef_valid_d;
            coef_index_q <= coef_index_d;
            coef_out_q   <= coef_out_d;
        end
    end

    assign readin_ok  = readin_ok_q;
    assign done       = done_q;
    assign coef_valid = coef_valid_q;
    assign coef_index = coef_index_q;
    assign coef_out   = coef_out_q;

endmodule

// File: tb/tb_kyber_pke_enc.sv
// Scoreboard bench for kyber_pke_enc: a byte-array message model predicts every
// coefficient; a negedge monitor pops and compares whatever the DUT streams.
module tb_kyber_pke_enc;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set = 1'b0;
    logic       readin = 1'b0;
    logic       full_in = 1'b0;
    logic [7:0] kyber_din = 8'h00;
    logic [7:0] kyber_in_index = 8'h00;
    logic       readin_ok, done, coef_valid;
    logic [7:0] coef_index;
    logic [11:0] coef_out;

    kyber_pke_enc #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .set(set), .readin(readin), .full_in(full_in),
        .kyber_din(kyber_din), .kyber_in_index(kyber_in_index),
        .readin_ok(readin_ok), .done(done), .coef_valid(coef_valid),
        .coef_index(coef_index), .coef_out(coef_out)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int val; } coef_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] mem [32];
    coef_t      exp_q [$];
    int         wr_i [$];
    int         wr_v [$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Message bit i lives in byte i/8 at bit position i%8; a 1 maps to ceil(q/2).
    task automatic push_expected();
        for (int i = 0; i < 256; i++) begin
            int b;
            b = (mem[i / 8] >> (i % 8)) & 1;
            exp_q.push_back('{idx: i, val: (b != 0) ? 1665 : 0});
        end
    endtask

    always @(negedge clk) begin
        if (reset && coef_valid) begin
            if (exp_q.size() == 0) begin
                chk("coef_unexpected", 1, 0);
            end else begin
                coef_t e;
                e = exp_q.pop_front();
                chk("coef_index", int'(coef_index), e.idx);
                chk("coef_value", int'(coef_out), e.val);
            end
        end
    end

    // Loads the queued writes (full_in on the last one), then tracks the stream.
    // abort_at > 0 stops after that many post-full_in edges.
    task automatic run_enc(input int abort_at);
        int n;
        n = wr_i.size();
        chk("readin_ok_in_load", readin_ok, 1);
        if (n == 0) begin
            full_in = 1'b1;
            push_expected();
            @(posedge clk); #1;
        end else begin
            for (int j = 0; j < n; j++) begin
                readin         = 1'b1;
                kyber_in_index = 8'(wr_i[j]);
                kyber_din      = 8'(wr_v[j]);
                mem[wr_i[j] % 32] = 8'(wr_v[j]);
                full_in = (j == n - 1);
                if (j == n - 1) push_expected();
                @(posedge clk); #1;
                if (j != n - 1 && $urandom_range(3) == 0) begin
                    readin = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        readin  = 1'b0;
        full_in = 1'b0;
        chk("readin_ok_fall", readin_ok, 0);
        for (int k = 1; k <= 257; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) break;
            if (k <= 256) chk("valid_continuous", coef_valid, 1);
            if (k == 256) chk("done_early", done, 0);
            if (k == 257) begin
                chk("done_rise", done, 1);
                chk("valid_fall", coef_valid, 0);
                chk("scoreboard_drained", exp_q.size(), 0);
            end
        end
        wr_i.delete();
        wr_v.delete();
    endtask

    task automatic end_run();
        set = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("readin_ok_idle", readin_ok, 0);
    endtask

    task automatic start_run();
        set = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readin_ok", readin_ok, 0);
        chk("rst_done", done, 0);
        chk("rst_coef_valid", coef_valid, 0);
        chk("rst_coef_out", int'(coef_out), 0);
        chk("rst_coef_index", int'(coef_index), 0);
        set = 1'b1;
        @(posedge clk); #1;
        chk("rst_held_readin_ok", readin_ok, 0);
        reset = 1'b1;
        #1;
        chk("rst_release_no_edge", readin_ok, 0);
        @(posedge clk); #1;
        chk("readin_ok_rise", readin_ok, 1);

        // All ones
        for (int i = 0; i < 32; i++) begin wr_i.push_back(i); wr_v.push_back(8'hFF); end
        run_enc(0);
        end_run();

        // Only first and last message bits set
        start_run();
        for (int i = 0; i < 32; i++) begin
            wr_i.push_back(i);
            wr_v.push_back(i == 0 ? 8'h01 : (i == 31 ? 8'h80 : 8'h00));
        end
        run_enc(0);
        end_run();

        // Index wrap and overwrite, full_in on the final write
        start_run();
        wr_i.push_back(1);  wr_v.push_back(8'h00);
        wr_i.push_back(33); wr_v.push_back(8'h0F);
        run_enc(0);
        end_run();

        // Idle: set low, readin/full_in must be ignored
        for (int c = 0; c < 5; c++) begin
            readin = 1'b1; full_in = 1'b1;
            kyber_in_index = 8'(c); kyber_din = 8'hA5;
            @(posedge clk); #1;
            chk("idle_readin_ok", readin_ok, 0);
            chk("idle_coef_valid", coef_valid, 0);
            chk("idle_done", done, 0);
        end
        readin = 1'b0; full_in = 1'b0;

        // Randomized partial loads; untouched bytes carry over
        for (int r = 0; r < 3; r++) begin
            int n;
            start_run();
            n = $urandom_range(40, 1);
            for (int j = 0; j < n; j++) begin
                wr_i.push_back($urandom_range(255));
                wr_v.push_back($urandom_range(255));
            end
            run_enc(0);
            end_run();
        end

        // Async reset at coefficient 100
        start_run();
        for (int j = 0; j < 32; j++) begin
            wr_i.push_back(j);
            wr_v.push_back($urandom_range(255, 1));
        end
        run_enc(101);
        #1;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        #1;
        chk("async_rst_valid", coef_valid, 0);
        chk("async_rst_readin_ok", readin_ok, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_coef_out", int'(coef_out), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reload_readin_ok", readin_ok, 1);
        run_enc(0);
        end_run();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kyber_pke_enc.md
# kyber_pke_enc

Message-encoding front end of the Kyber PKE encryption datapath. It loads a 32-byte message over a byte-wide handshake into an internal buffer. It expands each message bit into a polynomial coefficient, Decompress_q(Decode_1(m), 1): 0 or ⌈q/2⌉ = 1665 with q = 3329. It streams the 2^DEPTH coefficients out to the downstream polynomial-add stage, then signals completion.

## Interface
- DEPTH, default 8: coefficient address width. 2^DEPTH coefficients; message buffer holds 2^(DEPTH-3) bytes. Legal range 4..11.
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- set  input  1  level enable; run starts from IDLE while high.
- readin  input  1  producer has a valid byte on kyber_din / kyber_in_index.
- full_in  input  1  producer has finished loading; start encoding.
- kyber_din  input  8  message byte.
- kyber_in_index  input  8  byte address; only bits [DEPTH-4:0] are used.
- readin_ok  output  1  block accepts bytes (LOAD state).
- done  output  1  encoding finished.
- coef_valid  output  1  coef_out / coef_index valid this cycle.
- coef_index  output  DEPTH  coefficient number 0..2^DEPTH-1.
- coef_out  output  12  coefficient value, 0 or 1665.

## Operation
- States: IDLE, LOAD, ENCODE, DONE.
- IDLE -> LOAD when set=1. Otherwise IDLE holds; readin and full_in are ignored.
- LOAD: readin_ok=1. Each edge with readin=1 writes kyber_din into buffer[kyber_in_index[DEPTH-4:0]].
  - Indices above the buffer size wrap. For DEPTH=8, index 33 writes byte 1.
  - Repeated writes overwrite.
  - Unwritten bytes keep their previous contents.
- LOAD -> ENCODE on an edge with full_in=1.
  - A readin write on that same edge is still performed and is visible to ENCODE.
- ENCODE: counter i runs 0..2^DEPTH-1, one coefficient per cycle.
  - Bit b = buffer[i>>3][i&7], LSB-first.
  - coef_out = b ? 12'd1665 : 12'd0; coef_index = i; coef_valid = 1.
  - After i = 2^DEPTH-1, go to DONE.
- DONE: done=1 while set=1. set=0 -> IDLE, done=0.
- set=0 during LOAD or ENCODE does not abort the run; it only takes effect in DONE.
- Reset (reset=0): state IDLE; counter 0; buffer cleared to 0x00. All outputs 0: readin_ok, done, coef_valid, coef_index, coef_out.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- readin_ok rises on the edge entering LOAD (the first edge with set=1 after reset release). It falls on the edge that samples full_in=1.
- Latency: full_in sampled at edge N.
  - Coefficient 0 is presented after edge N+1.
  - Coefficient i is presented after edge N+1+i.
  - coef_valid falls and done rises at edge N+1+2^DEPTH (N+257 for DEPTH=8).
- coef_valid is continuous for exactly 2^DEPTH cycles; no backpressure.
- Asynchronous reset asserted mid-ENCODE: coef_valid, readin_ok and done drop immediately, without waiting for a clock. After release with set=1, a fresh LOAD starts; the buffer is zero.
- full_in and readin outside LOAD: no effect.

## Test plan
- Reset: hold reset=0 -> readin_ok=0, done=0, coef_valid=0, coef_out=0. Release with set=1 -> readin_ok=1 one edge later.
- Load bytes 0..31 = 0xFF, then full_in -> 256 consecutive cycles of coef_valid=1, coef_out=1665, coef_index 0..255. done=1 at edge N+257.
- Byte 0 = 0x01, byte 31 = 0x80, others 0x00 -> coef 0 = 1665, coef 255 = 1665, all others 0.
- Write index 1 = 0x00, then index 33 = 0x0F; full_in asserted with the final write -> coefs 8..11 = 1665, 12..15 = 0.
- set=0 with readin=1 and full_in=1 pulsed -> readin_ok stays 0, no coef_valid, no done.
- Reset asserted at coefficient 100 -> coef_valid=0 immediately. Reload with all-zero data -> all 256 coefs 0. done clears when set drops.
